// File: rtl/ncl_add_sequencer.sv
// Clocked wavefront sequencer for a dual-rail NULL-convention ripple adder.
// Drives DATA/NULL wavefronts, synchronizes the returned rails and captures the sum.
module ncl_add_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] b0,
    output logic [WIDTH-1:0] b1,
    output logic             ci0,
    output logic             ci1,
    input  logic [WIDTH-1:0] s0,
    input  logic [WIDTH-1:0] s1,
    input  logic             co0,
    input  logic             co1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err
);

    localparam int SW = 2 * WIDTH + 2;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_NULLW = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic [CW-1:0]   cnt_inc_s;
    logic            accept_s;
    logic            capture_s;
    logic            res_valid_s;
    logic [SW-1:0]   sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sy_s0_s;
    logic [WIDTH-1:0] sy_s1_s;
    logic            sy_co0_s;
    logic            sy_co1_s;
    logic            data_done_s;
    logic            null_done_s;
    logic            illegal_s;

    // Every bit carries exactly one high rail (both-high fails the xor test).
    function automatic logic all_data(input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1,
                                      input logic c0, input logic c1);
        return (&(r0 ^ r1)) & (c0 ^ c1);
    endfunction

    function automatic logic all_null(input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1,
                                      input logic c0, input logic c1);
        return ~(|{r0, r1, c0, c1});
    endfunction

    function automatic logic any_illegal(input logic [WIDTH-1:0] r0, input logic [WIDTH-1:0] r1,
                                         input logic c0, input logic c1);
        return (|(r0 & r1)) | (c0 & c1);
    endfunction

    // Synchronizer chain for all asynchronous rails returned by the adder.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= {co1, co0, s1, s0};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sy_s0_s  = sync_r[SYNC_STAGES-1][WIDTH-1:0];
    assign sy_s1_s  = sync_r[SYNC_STAGES-1][2*WIDTH-1:WIDTH];
    assign sy_co0_s = sync_r[SYNC_STAGES-1][2*WIDTH];
    assign sy_co1_s = sync_r[SYNC_STAGES-1][2*WIDTH+1];

    assign data_done_s = all_data(sy_s0_s, sy_s1_s, sy_co0_s, sy_co1_s);
    assign null_done_s = all_null(sy_s0_s, sy_s1_s, sy_co0_s, sy_co1_s);
    assign illegal_s   = any_illegal(sy_s0_s, sy_s1_s, sy_co0_s, sy_co1_s);
    assign cnt_inc_s   = cnt_r + CW'(1);

    // Next-state, phase counter and event decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (req_valid && req_ready) begin
                    accept_s = 1'b1;
                    state_s  = ST_DATA;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_DATA: begin
                // Illegal rails outrank a simultaneous completion.
                if (illegal_s) begin
                    state_s = ST_ERR;
                end else if (data_done_s) begin
                    capture_s = 1'b1;
                    cnt_s     = '0;
                    state_s   = ST_NULLW;
                end else if (cnt_inc_s == TO_C) begin
                    state_s = ST_ERR;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_NULLW: begin
                if (illegal_s) begin
                    state_s = ST_ERR;
                end else if (null_done_s) begin
                    cnt_s   = '0;
                    state_s = ST_IDLE;
                end else if (cnt_inc_s == TO_C) begin
                    state_s = ST_ERR;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_ERR: begin
                cnt_s   = '0;
                state_s = ST_ERR;
            end
            default: begin
                cnt_s   = '0;
                state_s = ST_ERR;
            end
        endcase
    end

    // Result handshake: capture sets, a consuming edge clears.
    always_comb begin
        res_valid_s = res_valid;
        if (capture_s) begin
            res_valid_s = 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid_s = 1'b0;
        end else begin
            res_valid_s = res_valid;
        end
    end

    // State, counter, rail drivers, result register and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            a0        <= '0;
            a1        <= '0;
            b0        <= '0;
            b1        <= '0;
            ci0       <= 1'b0;
            ci1       <= 1'b0;
            res_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                a1  <= a;
                a0  <= ~a;
                b1  <= b;
                b0  <= ~b;
                ci1 <= cin;
                ci0 <= ~cin;
            end else if (state_s != ST_DATA) begin
                a0  <= '0;
                a1  <= '0;
                b0  <= '0;
                b1  <= '0;
                ci0 <= 1'b0;
                ci1 <= 1'b0;
            end else begin
                a0  <= a0;
                a1  <= a1;
                b0  <= b0;
                b1  <= b1;
                ci0 <= ci0;
                ci1 <= ci1;
            end
            if (capture_s) begin
                sum  <= sy_s1_s;
                cout <= sy_co1_s;
            end else begin
                sum  <= sum;
                cout <= cout;
            end
            res_valid <= res_valid_s;
            err       <= (state_s == ST_ERR);
            req_ready <= (state_s == ST_IDLE) && !res_valid_s;
        end
    end

endmodule

// File: tb/tb_ncl_add_sequencer.sv
// Directed bench for ncl_add_sequencer with a behavioural dual-rail adder model
// that supports zero/10 ns rail delay, a stuck-NULL bit and an illegal-rail fault.
module tb_ncl_add_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] a0, a1, b0, b1;
    logic       ci0, ci1;
    logic [7:0] s0, s1;
    logic       co0, co1;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] sum;
    logic       cout;
    logic       err;

    int tests = 0;
    int fails = 0;
    int mode  = 0;
    logic slow = 1'b0;

    logic [17:0] m_bus;
    wire  [17:0] d_bus;
    logic [8:0]  full;
    logic        in_data;

    ncl_add_sequencer #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .b(b), .cin(cin),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .ci0(ci0), .ci1(ci1),
        .s0(s0), .s1(s1), .co0(co0), .co1(co1),
        .res_valid(res_valid), .res_ready(res_ready), .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural adder: DATA out only when every input rail pair is DATA.
    always_comb begin
        full    = {1'b0, a1} + {1'b0, b1} + {8'd0, ci1};
        in_data = (&(a0 ^ a1)) && (&(b0 ^ b1)) && (ci0 ^ ci1);
        m_bus   = 18'd0;
        if (in_data) begin
            m_bus = {full[8], ~full[8], full[7:0], ~full[7:0]};
        end
        if (mode == 1) begin
            m_bus[3]  = 1'b0;
            m_bus[11] = 1'b0;
        end
        if (mode == 2 && in_data) begin
            m_bus[0] = 1'b1;
            m_bus[8] = 1'b1;
        end
    end

    assign #10 d_bus = m_bus;
    assign {co1, co0, s1, s0} = slow ? d_bus : m_bus;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Slow-model add with the result held until a one-cycle consume pulse.
    task automatic do_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic [7:0] es, input logic ec);
        int n;
        a = va; b = vb; cin = vc; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_valid(n);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_sum"}, 32'({cout, sum}), 32'({ec, es}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_consumed"}, 32'(res_valid), 32'd0);
        wait_ready(n);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_null"}, 32'({co0, co1, s0, s1}), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
        a = 8'h00; b = 8'h00; cin = 1'b0;
        do_reset();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_status", 32'({res_valid, err, cout, sum}), 32'd0);
        chk("rst_rails", 32'({a0, a1, b0, b1}), 32'd0);

        // Latency with zero-delay model; operands changed after acceptance must not matter.
        a = 8'h12; b = 8'h34; cin = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
        chk("lat_rail_a", 32'({a1, a0}), 32'h12ED);
        chk("lat_rail_bc", 32'({b1, b0, ci1, ci0}), 32'({8'h34, 8'hCB, 2'b10}));
        chk("lat_busy", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("lat_e2_valid", 32'(res_valid), 32'd0);
        tick();
        chk("lat_e3_valid", 32'(res_valid), 32'd1);
        chk("lat_e3_sum", 32'({cout, sum}), 32'h047);
        chk("lat_e3_null", 32'({a0, a1, ci0, ci1}), 32'd0);
        tick();
        chk("lat_e4_consumed", 32'(res_valid), 32'd0);
        tick();
        chk("lat_e5_ready", 32'(req_ready), 32'd0);
        tick();
        chk("lat_e6_ready", 32'(req_ready), 32'd1);

        // Basic adds through a 10 ns rail delay.
        slow = 1'b1; res_ready = 1'b0;
        do_add("add1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        do_add("add2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_add("add3", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        slow = 1'b0;

        // Backpressure.
        a = 8'h0F; b = 8'hF0; cin = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_valid(n);
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", 32'({res_valid, req_ready, cout, sum}), 32'({1'b1, 1'b0, 1'b0, 8'hFF}));
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_release", 32'({res_valid, req_ready}), 32'b01);

        // Illegal rails during DATA.
        mode = 2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!err && n < 10) begin
            tick();
            n++;
        end
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_latency", 32'(n <= 3), 32'd1);
        chk("ill_state", 32'({res_valid, req_ready, a0, a1}), 32'd0);
        mode = 0;
        do_reset();
        chk("ill_reset", 32'({err, req_ready}), 32'b01);

        // Timeout on a stuck-NULL sum bit.
        mode = 1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        tick();
        chk("to_e15_err", 32'(err), 32'd0);
        tick();
        chk("to_e16_err", 32'(err), 32'd1);
        chk("to_rails", 32'({a0, a1, b0, b1, ci0, ci1}), 32'd0);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        req_valid = 1'b0;
        chk("to_sticky", 32'({err, req_ready, a1}), 32'({1'b1, 1'b0, 8'h00}));
        do_reset();

        // Reset in the middle of a DATA phase.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("mid_in_data", 32'(a0 | a1), 32'hFF);
        do_reset();
        chk("mid_rails", 32'({a0, a1, b0, b1, ci0, ci1}), 32'd0);
        chk("mid_status", 32'({res_valid, err, req_ready}), 32'b001);
        mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ncl_add_sequencer.md
# ncl_add_sequencer

Clocked wavefront sequencer for a WIDTH-bit dual-rail (NULL convention) ripple adder built from thfadd cells. It accepts single-rail operands over a valid/ready handshake and drives them onto the adder as a DATA wavefront. It detects completion, captures the sum, then drives a NULL wavefront and waits for the adder to return to all-NULL. It is the synchronous-to-NCL bridge that lets clocked logic use the asynchronous adder, and it flags stuck or illegal datapath behaviour.

## Interface
- WIDTH, 8, operand and sum width in bits
- SYNC_STAGES, 2, flops per synchronizer on every datapath output rail (≥2)
- TIMEOUT, 255, cycles allowed per wavefront phase before error (≥ SYNC_STAGES+2)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  operand request
- req_ready  out  1  request accepted when req_valid && req_ready at clk edge
- a, b  in  WIDTH  operands
- cin  in  1  carry in
- a0, a1, b0, b1  out  WIDTH  dual-rail operand rails to adder (registered)
- ci0, ci1  out  1  dual-rail carry-in rails (registered)
- s0, s1  in  WIDTH  dual-rail sum rails from adder (asynchronous)
- co0, co1  in  1  dual-rail carry-out rails (asynchronous)
- res_valid  out  1  result held until consumed
- res_ready  in  1  result consumed when res_valid && res_ready at edge
- sum  out  WIDTH  captured sum
- cout  out  1  captured carry out
- err  out  1  sticky fault flag

## Operation
- Rail encoding: NULL = both rails 0; DATA 0 = (x0=1,x1=0); DATA 1 = (x0=0,x1=1); both rails 1 = illegal.
- All s/co rails pass through SYNC_STAGES flops. NCL rails change monotonically within a phase (NULL→DATA, then DATA→NULL), so per-bit skew only delays detection and never produces a false result.
- data_done: every synced bit of s and co has exactly one rail high. null_done: all synced rails are 0. illegal: any synced bit has both rails high.
- States:
  - IDLE: rails NULL. req_ready = !res_valid. On accept, register a/b/cin onto the rails (x1 = bit, x0 = ~bit) and go to DATA.
  - DATA: hold DATA rails. On data_done: load sum = synced s1 and cout = synced co1, set res_valid, drive all rails NULL, go to NULLW.
  - NULLW: hold NULL rails. On null_done, go to IDLE.
  - ERR: rails NULL, req_ready=0, err=1. Only reset leaves ERR.
- Phase counter clears on entry to DATA and NULLW and increments each cycle in those states. If it reaches TIMEOUT without the phase's done condition, go to ERR.
- illegal seen in DATA or NULLW → ERR on the next edge. It takes priority over data_done in the same cycle.
- res_valid clears on a consuming edge. The result register is independent of state, so consumption may occur in NULLW or IDLE.
- req_ready is 0 in DATA, NULLW and ERR, and whenever res_valid=1.

## Timing
- Reset values: all rails 0, req_ready 1 (IDLE, res_valid 0), res_valid 0, sum 0, cout 0, err 0, counter 0, sync flops 0.
- Reset mid-operation: at the reset edge all rails go NULL and state goes to IDLE. Any pending result and err are discarded.
- Acceptance at edge E0 → DATA rails valid after E0.
- With zero datapath delay: synced complete after E0+SYNC_STAGES, capture edge E0+SYNC_STAGES+1. res_valid=1 and rails NULL after that edge, i.e. minimum 3 cycles at SYNC_STAGES=2.
- NULLW exit: IDLE after E0+2·(SYNC_STAGES+1) minimum. req_ready rises then, provided res_valid=0.
- Datapath delay D cycles adds D to each phase.
- Timeout: ERR entered at the edge where the counter equals TIMEOUT with the done condition still false.
- req_valid in a non-IDLE state is ignored. Operands are sampled only on the acceptance edge.

## Test plan
- Reset: assert reset 2 cycles mid-DATA → next cycle all rails 0, res_valid 0, err 0, req_ready 1.
- Basic add: behavioural adder model with 10 ns rail delay. a=0x5A, b=0x3C, cin=0 → sum=0x96, cout=0; a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. After each, rails return to NULL before the next acceptance.
- Latency: zero-delay model, SYNC_STAGES=2 → res_valid exactly 3 cycles after acceptance; req_ready back 6 cycles after acceptance with res_ready held 1.
- Backpressure: res_ready=0 for 20 cycles → res_valid, sum and cout stable and req_ready=0. One res_ready pulse → res_valid falls, req_ready=1 next cycle.
- Timeout: model holds s bit 3 at NULL forever, TIMEOUT=16 → err=1 at the 16th DATA cycle, rails NULL, req_ready=0, stays in ERR until reset.
- Illegal rails: model drives s0[0]=s1[0]=1 during DATA → ERR within SYNC_STAGES+1 cycles, res_valid stays 0.
